stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Synchronous initiator for the 4-bit, 8-entry LIFO stack. Converts single-cycle host commands into correctly sequenced Push/Pop strobes and drives or releases the shared bidirectional DataIO bus. Captures popped data and the stack's Full/Empty/Err flags into a one-cycle response, and keeps its own occupancy count. Sits between the datapath sequencer and the stack.

## Interface
- BLOCK_ON_FLAG, 1: 1 = reject push-when-Full and pop-when-Empty locally, without strobing the stack; 0 = forward every command and report the stack's Err.
- Clk  input  1  single clock; all state changes on rising edge.
- Rst  input  1  asynchronous, active-high reset.
- CmdValid  input  1  host command present.
- CmdOp  input  1  0 = push, 1 = pop.
- CmdData  input  4  push data.
- CmdReady  output  1  high only in IDLE; command accepted when CmdValid && CmdReady.
- RspValid  output  1  one-cycle response strobe.
- RspData  output  4  popped word (valid with RspValid on pop); 0 on push responses.
- RspErr  output  1  error for this command (valid with RspValid).
- Level  output  4  controller occupancy count, 0..8.
- Push  output  1  stack push strobe.
- Pop  output  1  stack pop strobe.
- DataIO  inout  4  shared stack data bus.
- SP  input  3  stack pointer (monitored only).
- Full, Empty, Err  input  1 each  stack flags.

## Operation
- States: IDLE, PS_SETUP, PS_STROBE, PS_HOLD, PP_STROBE, PP_SAMPLE, PP_RELEASE, DONE, REJECT.
- IDLE: CmdReady=1. On accept, latch CmdOp/CmdData.
  - With BLOCK_ON_FLAG=1, a push while Full=1 or a pop while Empty=1 goes to REJECT.
  - Otherwise a push goes to PS_SETUP and a pop goes to PP_STROBE.
- Push sequence:
  - PS_SETUP: drive DataIO=latched data, Push=0.
  - PS_STROBE: Push=1, bus driven.
  - PS_HOLD: Push=0, bus still driven.
  - Then DONE.
- Pop sequence:
  - PP_STROBE: Pop=1, DataIO released.
  - PP_SAMPLE: Pop=1; register DataIO at end of cycle.
  - PP_RELEASE: Pop=0.
  - Then DONE.
- DONE:
  - RspValid=1. RspErr=Err input as sampled in DONE. RspData=captured word for a pop, 0 for a push. Bus released.
  - Level updates only if RspErr=0: push increments with saturation at 8; pop decrements with floor at 0.
  - Next state: IDLE.
- REJECT: RspValid=1, RspErr=1, RspData=0, Level unchanged, no strobe; next state IDLE.
- DataIO is driven only in PS_SETUP, PS_STROBE and PS_HOLD; high-Z in every other state and during reset. Push and Pop are never high in the same cycle.
- CmdValid is ignored outside IDLE; the host must hold a command until it is accepted.

## Timing
- Reset values: CmdReady=1 (state IDLE), RspValid=0, RspData=0, RspErr=0, Level=0, Push=0, Pop=0, DataIO=Z.
- Push/Pop are registered outputs, glitch-free, each high for exactly one Clk cycle.
- Push strobe: data is stable one full cycle before the Push rising edge and one full cycle after the falling edge.
- Latency: accepted cycle N gives RspValid in cycle N+4 for a forwarded command and in N+1 for REJECT. The next command can be accepted in N+5 (forwarded) or N+2 (REJECT).
- Throughput: one stack operation per 5 cycles.
- Pop capture samples DataIO at the end of the second Pop-high cycle. The stack's output has a full cycle to settle.
- Rst asserted mid-sequence immediately forces Push=0, Pop=0, DataIO=Z, RspValid=0 and state IDLE, and clears Level. No response is issued for the aborted command.
- Level, SP and the flags are not cross-checked. Level may differ from SP after a stack Err or a reset of only one side.

## Test plan
- Reset then push 4'hA: Push is high exactly in cycle N+2; DataIO=4'hA in N+1..N+3 and Z in N+4; RspValid=1, RspErr=0 in N+4; Level=1.
- Push 4'h1..4'h8 then pop 8 times: RspData sequence is 8,7,…,1, all with RspErr=0. Level goes 8 then 0; Full seen after the 8th push, Empty after the 8th pop.
- BLOCK_ON_FLAG=1, pop on an empty stack: no Pop pulse; RspValid=1, RspErr=1 in N+1; Level stays 0.
- BLOCK_ON_FLAG=0, push a 9th word while Full: Push pulses; RspErr=1 reflecting the stack's Err; Level stays 8.
- Assert Rst during PS_STROBE: Push=0 and DataIO=Z immediately; no RspValid; CmdReady=1 after reset release.
- Hold CmdValid continuously with alternating push/pop: acceptances are spaced 5 cycles apart; Push and Pop are never high together; DataIO is never driven while Pop=1.

Source files
------------

// File: rtl/stack_ctrl.sv
// stack_ctrl
// Host-side initiator for a 4-bit x 8-entry LIFO stack. It turns one-cycle
// host commands into sequenced Push/Pop strobes and drives or releases the
// shared data bus. It returns a one-cycle response carrying the popped word
// and an error flag, and it keeps its own occupancy count.
//
// Ports
//   clk, rst         : clock, asynchronous active-high reset
//   cmd_valid/ready  : host command handshake (ready only in IDLE)
//   cmd_op           : 0 = push, 1 = pop
//   cmd_data         : push data
//   rsp_valid        : one-cycle response strobe
//   rsp_data         : popped word (0 on push and reject responses)
//   rsp_err          : error for the command being answered
//   level            : controller occupancy count, 0..8
//   push, pop        : stack strobes
//   data_io          : shared bidirectional stack data bus
//   sp               : stack pointer, observed but not used
//   full, empty, err : stack flags
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | ready for a command
// PS_SETUP   | bus driven with push data, strobe still low
// PS_STROBE  | push strobe high, bus driven
// PS_HOLD    | strobe low again, bus still driven for hold time
// PP_STROBE  | first pop-high cycle, bus released to the stack
// PP_SAMPLE  | second pop-high cycle, bus captured at its end
// PP_RELEASE | pop strobe low
// DONE       | response for a forwarded command, level update
// REJECT     | local error response, stack untouched

module stack_ctrl #(
    parameter bit BLOCK_ON_FLAG = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic       cmd_op,
    input  logic [3:0] cmd_data,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic [3:0] rsp_data,
    output logic       rsp_err,
    output logic [3:0] level,
    output logic       push,
    output logic       pop,
    inout  wire  [3:0] data_io,
    input  logic [2:0] sp,
    input  logic       full,
    input  logic       empty,
    input  logic       err
);

    typedef enum logic [3:0] {
        IDLE,
        PS_SETUP,
        PS_STROBE,
        PS_HOLD,
        PP_STROBE,
        PP_SAMPLE,
        PP_RELEASE,
        DONE,
        REJECT
    } state_t;

    state_t     state;
    logic       op_q;
    logic [3:0] data_q;
    logic [3:0] cap_q;
    logic       drive;
    logic       rsp_rej;
    logic       unused_sp;

    assign unused_sp = ^sp;

    assign data_io = drive ? data_q : 4'bzzzz;

    // The stack's Err is taken live during DONE so the response reflects the
    // flag as it stands in the response cycle; REJECT always reports an error.
    assign rsp_err = rsp_valid & (rsp_rej | err);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= 4'h0;
            rsp_rej   <= 1'b0;
            level     <= 4'd0;
            push      <= 1'b0;
            pop       <= 1'b0;
            drive     <= 1'b0;
            op_q      <= 1'b0;
            data_q    <= 4'h0;
            cap_q     <= 4'h0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_data  <= 4'h0;
            rsp_rej   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        data_q    <= cmd_data;
                        cmd_ready <= 1'b0;
                        if (BLOCK_ON_FLAG && ((!cmd_op && full) || (cmd_op && empty))) begin
                            state     <= REJECT;
                            rsp_valid <= 1'b1;
                            rsp_rej   <= 1'b1;
                        end else if (!cmd_op) begin
                            state <= PS_SETUP;
                            drive <= 1'b1;
                        end else begin
                            state <= PP_STROBE;
                            pop   <= 1'b1;
                        end
                    end
                end
                PS_SETUP: begin
                    state <= PS_STROBE;
                    push  <= 1'b1;
                end
                PS_STROBE: begin
                    state <= PS_HOLD;
                    push  <= 1'b0;
                end
                PS_HOLD: begin
                    state     <= DONE;
                    drive     <= 1'b0;
                    rsp_valid <= 1'b1;
                end
                PP_STROBE: begin
                    state <= PP_SAMPLE;
                end
                PP_SAMPLE: begin
                    state <= PP_RELEASE;
                    pop   <= 1'b0;
                    cap_q <= data_io;
                end
                PP_RELEASE: begin
                    state     <= DONE;
                    rsp_valid <= 1'b1;
                    rsp_data  <= cap_q;
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    if (!err) begin
                        if (!op_q && level != 4'd8) begin
                            level <= level + 4'd1;
                        end else if (op_q && level != 4'd0) begin
                            level <= level - 4'd1;
                        end
                    end
                end
                REJECT: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    push      <= 1'b0;
                    pop       <= 1'b0;
                    drive     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Testbench for stack_ctrl. Two instances run side by side, one rejecting
// locally on Full/Empty and one forwarding every command. Each has its own
// emulated LIFO stack on a pulled-up bus (a released bus reads as 4'hF, and
// push data is kept below 4'hF so driven and released are distinguishable).
// Expected responses come from a queue-based stack model and the latency
// rules; a monitor compares strobes, bus, ready, level and responses each cycle.

module tb_stack_ctrl;

    typedef struct {
        int         cyc;
        logic [3:0] data;
        logic       err;
        int         lvl;
    } rsp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g
        localparam bit BLK = (k == 0);
        localparam int ID  = k;

        logic       rst = 1'b1;
        logic       cmd_valid = 1'b0;
        logic       cmd_op = 1'b0;
        logic [3:0] cmd_data = 4'h0;
        logic       cmd_ready, rsp_valid, rsp_err, push, pop;
        logic [3:0] rsp_data, level;
        tri1  [3:0] bus;

        // emulated stack: commits a push on the strobe edge and a pop at the
        // end of the second pop-high cycle; drives its top word while pop=1
        logic [3:0] smem [8];
        int         scnt = 0;
        logic       s_err = 1'b0;
        logic       pop_q = 1'b0;
        logic       s_full, s_empty;
        logic [2:0] s_sp;
        logic [3:0] s_top;

        assign s_full  = (scnt == 8);
        assign s_empty = (scnt == 0);
        assign s_sp    = scnt[2:0];
        always_comb s_top = (scnt == 0) ? 4'h0 : smem[3'(scnt - 1)];
        assign bus = pop ? s_top : 4'bzzzz;

        always @(posedge clk) begin
            pop_q <= pop;
            if (push) begin
                if (scnt == 8) s_err <= 1'b1;
                else begin
                    smem[scnt[2:0]] <= bus;
                    scnt  <= scnt + 1;
                    s_err <= 1'b0;
                end
            end else if (pop && pop_q) begin
                if (scnt == 0) s_err <= 1'b1;
                else begin
                    scnt  <= scnt - 1;
                    s_err <= 1'b0;
                end
            end
        end

        stack_ctrl #(.BLOCK_ON_FLAG(BLK)) dut (
            .clk(clk), .rst(rst),
            .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
            .cmd_ready(cmd_ready),
            .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
            .level(level), .push(push), .pop(pop),
            .data_io(bus), .sp(s_sp),
            .full(s_full), .empty(s_empty), .err(s_err)
        );

        // reference model and scoreboard state
        logic [3:0] ref_stk [$];
        logic [3:0] saved [$];
        int         ref_level = 0;
        int         exp_level = 0;
        rsp_t       exp_q [$];
        int         act_kind = 0;     // 0 none, 1 push, 2 pop, 3 reject
        int         act_cycle = 0;
        logic [3:0] act_bus = 4'h0;
        int         last_acc = 0;
        int         last_gap = 0;
        bit         in_rst = 1'b1;

        always @(negedge clk) begin
            int d;
            int er, ep, eq, eb;
            if (!in_rst) begin
                d  = cyc - act_cycle;
                er = (act_kind == 0 || d == 0 || (act_kind == 3 ? d >= 2 : d >= 5)) ? 1 : 0;
                ep = (act_kind == 1 && d == 2) ? 1 : 0;
                eq = (act_kind == 2 && (d == 1 || d == 2)) ? 1 : 0;
                if ((act_kind == 1 && d >= 1 && d <= 3) || eq == 1) eb = act_bus;
                else eb = 15;
                chk($sformatf("i%0d cmd_ready", ID), cmd_ready, er);
                chk($sformatf("i%0d push", ID), push, ep);
                chk($sformatf("i%0d pop", ID), pop, eq);
                chk($sformatf("i%0d push_and_pop", ID), push & pop, 0);
                chk($sformatf("i%0d data_io", ID), bus, eb);
                chk($sformatf("i%0d level", ID), level, exp_level);
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    chk($sformatf("i%0d rsp_valid", ID), rsp_valid, 1);
                    chk($sformatf("i%0d rsp_data", ID), rsp_data, exp_q[0].data);
                    chk($sformatf("i%0d rsp_err", ID), rsp_err, exp_q[0].err);
                    exp_level = exp_q[0].lvl;
                    void'(exp_q.pop_front());
                end else begin
                    chk($sformatf("i%0d rsp_valid_idle", ID), rsp_valid, 0);
                end
            end
        end

        task automatic issue(input bit op, input logic [3:0] d, input bit hold, input bit gap_chk);
            int n;
            rsp_t r;
            bit rej, e;
            logic [3:0] pd;
            cmd_valid = 1'b1;
            cmd_op    = op;
            cmd_data  = d;
            n = 0;
            while (!cmd_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (!cmd_ready) begin
                chk($sformatf("i%0d accept_timeout", ID), 0, 1);
                cmd_valid = 1'b0;
                return;
            end
            if (gap_chk) chk($sformatf("i%0d accept_gap", ID), cyc - last_acc, last_gap);
            pd = 4'h0;
            e  = 1'b0;
            if (!op) begin
                rej = BLK && ref_stk.size() == 8;
                if (!rej) begin
                    e = (ref_stk.size() == 8);
                    if (!e) begin
                        ref_stk.push_back(d);
                        if (ref_level < 8) ref_level++;
                    end
                end
            end else begin
                rej = BLK && ref_stk.size() == 0;
                if (!rej) begin
                    e = (ref_stk.size() == 0);
                    if (!e) begin
                        pd = ref_stk.pop_back();
                        if (ref_level > 0) ref_level--;
                    end
                end
            end
            r.cyc  = cyc + (rej ? 1 : 4);
            r.data = pd;
            r.err  = rej | e;
            r.lvl  = ref_level;
            exp_q.push_back(r);
            act_cycle = cyc;
            act_kind  = rej ? 3 : (op ? 2 : 1);
            act_bus   = op ? pd : d;
            last_gap  = rej ? 2 : 5;
            last_acc  = cyc;
            @(negedge clk);
            if (!hold) cmd_valid = 1'b0;
        endtask

        task automatic wait_idle();
            int n;
            n = 0;
            while ((exp_q.size() > 0 || !cmd_ready) && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) chk($sformatf("i%0d idle_timeout", ID), 0, 1);
            @(negedge clk);
        endtask

        initial begin
            in_rst = 1'b1;
            rst    = 1'b1;
            repeat (3) @(negedge clk);
            chk($sformatf("i%0d rst cmd_ready", ID), cmd_ready, 1);
            chk($sformatf("i%0d rst rsp_valid", ID), rsp_valid, 0);
            chk($sformatf("i%0d rst rsp_data", ID), rsp_data, 0);
            chk($sformatf("i%0d rst rsp_err", ID), rsp_err, 0);
            chk($sformatf("i%0d rst level", ID), level, 0);
            chk($sformatf("i%0d rst push", ID), push, 0);
            chk($sformatf("i%0d rst pop", ID), pop, 0);
            chk($sformatf("i%0d rst data_io", ID), bus, 15);
            rst    = 1'b0;
            in_rst = 1'b0;
            @(negedge clk);

            issue(1'b0, 4'hA, 1'b0, 1'b0);
            wait_idle();

            // abort a push while its strobe is high
            saved = ref_stk;
            issue(1'b0, 4'h5, 1'b0, 1'b0);
            @(posedge clk);
            #2;
            in_rst = 1'b1;
            rst    = 1'b1;
            #1;
            chk($sformatf("i%0d abort push", ID), push, 0);
            chk($sformatf("i%0d abort data_io", ID), bus, 15);
            chk($sformatf("i%0d abort rsp_valid", ID), rsp_valid, 0);
            chk($sformatf("i%0d abort level", ID), level, 0);
            exp_q.delete();
            ref_stk   = saved;
            ref_level = 0;
            exp_level = 0;
            act_kind  = 0;
            @(negedge clk);
            @(negedge clk);
            rst    = 1'b0;
            in_rst = 1'b0;
            chk($sformatf("i%0d abort cmd_ready", ID), cmd_ready, 1);
            @(negedge clk);

            // stack still holds 4'hA while the controller level is 0
            issue(1'b1, 4'h0, 1'b0, 1'b0);
            wait_idle();
            issue(1'b1, 4'h0, 1'b0, 1'b0);
            wait_idle();

            for (int i = 1; i <= 8; i++) issue(1'b0, 4'(i), 1'b0, 1'b0);
            wait_idle();
            chk($sformatf("i%0d full_after_8", ID), s_full, 1);
            issue(1'b0, 4'h9, 1'b0, 1'b0);
            wait_idle();
            for (int i = 0; i < 8; i++) issue(1'b1, 4'h0, 1'b0, 1'b0);
            wait_idle();
            chk($sformatf("i%0d empty_after_8", ID), s_empty, 1);

            // cmd_valid held high, alternating push/pop
            for (int i = 0; i < 12; i++)
                issue(1'(i % 2), 4'($urandom_range(0, 14)), 1'b1, i > 0);
            cmd_valid = 1'b0;
            wait_idle();

            for (int i = 0; i < 60; i++) begin
                int gap;
                gap = $urandom_range(0, 3);
                repeat (gap) @(negedge clk);
                issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 14)), gap == 0, 1'b0);
            end
            cmd_valid = 1'b0;
            wait_idle();
            done[ID] = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(done[0] && done[1]) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!(done[0] && done[1])) chk("run_timeout", 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
